// File: rtl/score_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : score_scan_driver
//  Description : Converts a 16-bit binary score (saturated at 9999) to four
//                BCD digits with an iterative shift-add-3 engine and
//                time-multiplexes them onto a 4-digit common-segment display.
//                Optional macro SCORE_LZ_BLANK_EN enables leading-zero
//                blanking (blanked digits present value 15).
//  Revision    : 1.0 - initial release
// ============================================================================
module score_scan_driver #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    output logic [31:0] digit,
    output logic [3:0]  anode,
    output logic        busy
);

    localparam int                 c_CNT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [13:0]        c_SAT_MAX = 14'd9999;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CONV   = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    // Conversion engine state
    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_iter;
    logic [15:0] r_bin;
    logic [15:0] r_acc;
    logic [13:0] r_cap;
    logic [13:0] r_shown;
    logic [15:0] r_bcd;
    logic        r_busy;

    // Scan state
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [31:0]        r_digit;
    logic [3:0]         r_anode;

    logic [13:0] w_sat;
    logic        w_start;
    logic [15:0] w_adj;
    logic        w_wrap;
    logic [1:0]  w_idx_next;
    logic [3:0]  w_nib;
    logic [31:0] w_slot_val;

    // Saturated score; comparing the saturated value keeps a steady
    // out-of-range score from retriggering conversions.
    assign w_sat   = (score > 16'd9999) ? c_SAT_MAX : score[13:0];
    assign w_start = (r_state == c_ST_IDLE) && (w_sat != r_shown);

    // Add-3 correction of every BCD nibble that is 5 or more
    for (genvar n = 0; n < 4; n++) begin : g_adj
        assign w_adj[4*n +: 4] = (r_acc[4*n +: 4] >= 4'd5) ? (r_acc[4*n +: 4] + 4'd3)
                                                             : r_acc[4*n +: 4];
    end

    // Next-state decode for the conversion FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_start) w_state_next = c_ST_CONV;
            c_ST_CONV:   if (r_iter == 4'd15) w_state_next = c_ST_COMMIT;
            c_ST_COMMIT: w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // State register; busy also covers the cycle in which the commit lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != c_ST_IDLE) || (r_state == c_ST_COMMIT);
        end
    end

    // Capture, shift-add-3 iterations and commit of the converted value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter  <= 4'd0;
            r_bin   <= 16'd0;
            r_acc   <= 16'd0;
            r_cap   <= 14'd0;
            r_shown <= 14'd0;
            r_bcd   <= 16'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_bin  <= {2'b00, w_sat};
                        r_acc  <= 16'd0;
                        r_cap  <= w_sat;
                        r_iter <= 4'd0;
                    end
                end
                c_ST_CONV: begin
                    r_acc  <= {w_adj[14:0], r_bin[15]};
                    r_bin  <= {r_bin[14:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                end
                c_ST_COMMIT: begin
                    r_bcd   <= r_acc;
                    r_shown <= r_cap;
                end
                default: ;
            endcase
        end
    end

    assign w_wrap     = (r_cnt == c_CNT_MAX);
    assign w_idx_next = r_idx + 2'd1;
    assign w_nib      = r_bcd[{w_idx_next, 2'b00} +: 4];

`ifdef SCORE_LZ_BLANK_EN
    logic [3:0] w_blank;
    // Digit i>0 is blank when it and every higher nibble are zero
    assign w_blank[0] = 1'b0;
    assign w_blank[1] = (r_bcd[15:4]  == 12'd0);
    assign w_blank[2] = (r_bcd[15:8]  == 8'd0);
    assign w_blank[3] = (r_bcd[15:12] == 4'd0);

    // Value presented in the upcoming slot, with blanking code 15
    always_comb begin
        w_slot_val = {28'd0, w_nib};
        if (w_blank[w_idx_next]) w_slot_val = 32'd15;
    end
`else
    // Value presented in the upcoming slot
    always_comb begin
        w_slot_val = {28'd0, w_nib};
    end
`endif

    // Refresh counter and registered slot outputs, updated together on wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_anode <= 4'b1110;
            r_digit <= 32'd0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_idx   <= w_idx_next;
            r_anode <= ~(4'b0001 << w_idx_next);
            r_digit <= w_slot_val;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign digit = r_digit;
    assign anode = r_anode;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_score_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_scan_driver
//  Description : Scoreboard bench for score_scan_driver. Stimulus pushes the
//                expected displayed value per conversion; a monitor pops it
//                when busy falls and checks every scan slot afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_scan_driver;

    localparam int c_REFRESH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] score;
    logic [31:0] digit;
    logic [3:0]  anode;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_shown = 0;

    score_scan_driver #(.REFRESH_CYCLES(c_REFRESH)) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .digit (digit),
        .anode (anode),
        .busy  (busy)
    );

    // Free-running clock, 10 time units period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    // Expected slot value for digit position i of decimal number v
    function automatic logic [31:0] exp_digit(input int v, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
`ifdef SCORE_LZ_BLANK_EN
        if (i > 0 && v < p) return 32'd15;
`endif
        return 32'((v / p) % 10);
    endfunction

    function automatic int idx_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return 0;
        endcase
    endfunction

    // Apply a score and hold it; a conversion is expected only when the
    // saturated value differs from what is already displayed.
    task automatic apply(input int v, input int hold);
        @(negedge clk);
        score = v[15:0];
        if (sat(v) != model_shown) begin
            model_shown = sat(v);
            exp_q.push_back(model_shown);
        end
        repeat (hold) @(negedge clk);
    endtask

    // Monitor: busy length, scan sequence/duty, and slot digits
    initial begin
        logic       prev_busy;
        logic [3:0] prev_anode;
        int         busy_run;
        int         run;
        int         cur_val;
        prev_busy  = 1'b0;
        prev_anode = 4'b1110;
        busy_run   = 0;
        run        = 1;
        cur_val    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_busy  = 1'b0;
                prev_anode = 4'b1110;
                busy_run   = 0;
                run        = 1;
                cur_val    = 0;
            end else begin
                if (busy) busy_run++;
                if (prev_busy && !busy) begin
                    chk("busy_len", busy_run, 18);
                    busy_run = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL conv_expected: actual extra conversion required none (t=%0t)", $time);
                    end else begin
                        cur_val = exp_q.pop_front();
                    end
                end
                prev_busy = busy;
                if (anode == prev_anode) begin
                    run++;
                end else begin
                    chk("slot_len", run, c_REFRESH);
                    chk("anode_seq", {28'd0, anode}, {28'd0, prev_anode[2:0], prev_anode[3]});
                    run        = 1;
                    prev_anode = anode;
                    if (!busy) chk("slot_digit", digit, exp_digit(cur_val, idx_of(anode)));
                end
            end
        end
    end

    // Stimulus
    initial begin
        int mode;
        int v;
        rst   = 1'b1;
        score = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_digit", digit, 32'd0);
        chk("rst_anode", {28'd0, anode}, 32'b1110);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Idle at zero over a full scan period: no conversion expected
        apply(0, 4 * c_REFRESH + 4);
        apply(1234, 60);
        apply(50000, 200);
        apply(42, 60);
        apply(65535, 60);
        apply(12000, 60);
        apply(9999, 60);
        apply(10000, 60);

        for (int n = 0; n < 20; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       v = int'($urandom_range(0, 65535));
                1:       v = int'($urandom_range(0, 99));
                2:       v = int'(score);
                default: v = int'($urandom_range(10000, 65535));
            endcase
            apply(v, 60 + int'($urandom_range(0, 15)));
        end

        // Abort a conversion with reset
        apply(1000, 60);
        @(negedge clk);
        score = 16'd77;
        repeat (2) @(negedge clk);
        chk("busy_in_conv", {31'd0, busy}, 32'd1);
        score = 16'd5;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_digit", digit, 32'd0);
        chk("async_rst_anode", {28'd0, anode}, 32'b1110);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_shown = 5;
        exp_q.push_back(5);
        repeat (60) @(negedge clk);

        chk("pending_convs", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
